// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch queue.
package if_pkg;

  localparam int XLEN_DEFAULT   = 32;
  localparam int QDEPTH_DEFAULT = 4;
  localparam int CNT_W          = $clog2(QDEPTH_DEFAULT) + 1;

  localparam logic [XLEN_DEFAULT-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [XLEN_DEFAULT-1:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/if_fetch_queue_fifo.sv
// QDEPTH-entry synchronous FIFO of fetch entries; head is read directly from storage (no bypass).
module fetch_fifo
  import if_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  output fetch_entry_t               head,
  output logic [$clog2(QDEPTH):0]    count
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop_ok;

  fetch_entry_t entry_q [QDEPTH];
  fetch_entry_t entry_d [QDEPTH];

  assign pop_ok = pop && (count_q != '0);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push)   wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_ok) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: count gates every read of it.
  generate
    for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_entry
      always_comb begin
        entry_d[gi] = entry_q[gi];
        if (push && !flush && (wr_ptr_q == PW'(gi))) entry_d[gi] = push_data;
      end
      always_ff @(posedge clk) entry_q[gi] <= entry_d[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset && !flush) assert (!(push && !pop_ok && (count_q == CW'(QDEPTH))));
  end

  assign head  = entry_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction fetch with prefetch queue, 1-cycle imem, redirect flush.
// Optional FETCH_PERF_EN adds saturating fetch/flush/stall counters.
module if_fetch_queue
  import if_pkg::*;
#(
  parameter int                 XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0]    RESET_PC = '0,
  parameter int                 QDEPTH   = QDEPTH_DEFAULT,
  parameter int                 IMEM_AW  = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 redirect_valid,
  input  logic [XLEN-1:0]      redirect_pc,
  output logic                 imem_req,
  output logic [IMEM_AW-1:0]   imem_addr,
  input  logic [XLEN-1:0]      imem_rdata,
  input  logic                 id_ready,
  output logic                 if_valid,
  output logic [XLEN-1:0]      if_instr,
  output logic [XLEN-1:0]      if_pc,
  output logic                 if_flush
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]          perf_fetched,
  output logic [31:0]          perf_flushes,
  output logic [31:0]          perf_stall
`endif
);

  localparam int CW = $clog2(QDEPTH) + 1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic            inflight_q, inflight_d;
  logic [CW-1:0]   count;
  logic [CW:0]     occupancy;
  logic            issue;
  logic            push;
  logic            pop;
  fetch_entry_t    push_data;
  fetch_entry_t    head;
  logic            unused_ok;

  assign unused_ok = &{1'b0, redirect_pc[1:0]};

  // Pending response counts against capacity so the push can never overflow.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight_q};
  assign issue     = !reset && !redirect_valid && (occupancy < (CW+1)'(QDEPTH));
  assign push      = inflight_q && !redirect_valid;
  assign pop       = if_valid && id_ready && !redirect_valid;
  assign push_data = '{pc: resp_pc_q, instr: imem_rdata};

  always_comb begin
    pc_d       = pc_q;
    resp_pc_d  = resp_pc_q;
    inflight_d = 1'b0;
    if (redirect_valid) begin
      pc_d = {redirect_pc[XLEN-1:2], 2'b00};
    end else if (issue) begin
      inflight_d = 1'b1;
      resp_pc_d  = pc_q;
      pc_d       = pc_q + XLEN'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      resp_pc_q  <= '0;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
    end
  end

  fetch_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign imem_req  = issue;
  assign imem_addr = pc_q[IMEM_AW+1:2];
  assign if_valid  = (count != '0);
  assign if_instr  = if_valid ? head.instr : '0;
  assign if_pc     = if_valid ? head.pc    : '0;
  assign if_flush  = redirect_valid;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_flushes_q, perf_flushes_d;
  logic [31:0] perf_stall_q,   perf_stall_d;

  always_comb begin
    perf_fetched_d = push ? sat_inc(perf_fetched_q) : perf_fetched_q;
    perf_flushes_d = redirect_valid ? sat_inc(perf_flushes_q) : perf_flushes_q;
    perf_stall_d   = ((count == CW'(QDEPTH)) && !id_ready) ? sat_inc(perf_stall_q) : perf_stall_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched_q <= '0;
      perf_flushes_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_flushes_q <= perf_flushes_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_flushes = perf_flushes_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue against a transaction-level queue model.
module tb_if_fetch_queue;

  localparam int QD = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;

  logic        imem_req,  imem_req2;
  logic [5:0]  imem_addr, imem_addr2;
  logic [31:0] imem_rdata, imem_rdata2;
  logic        if_valid,  if_valid2;
  logic [31:0] if_instr,  if_instr2;
  logic [31:0] if_pc,     if_pc2;
  logic        if_flush,  if_flush2;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_flushes, perf_stall;
  logic [31:0] perf_fetched2, perf_flushes2, perf_stall2;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [5:0] a);
    return 32'h1000_0000 + {26'd0, a};
  endfunction

  always @(posedge clk) begin
    if (imem_req)  imem_rdata  <= rom(imem_addr);
    if (imem_req2) imem_rdata2 <= rom(imem_addr2);
  end

  if_fetch_queue #(.XLEN(32), .RESET_PC(32'h0000_0000), .QDEPTH(QD), .IMEM_AW(6)) dut (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .id_ready(id_ready), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_flush(if_flush)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_flushes(perf_flushes), .perf_stall(perf_stall)
`endif
  );

  if_fetch_queue #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .QDEPTH(QD), .IMEM_AW(6)) dut_wrap (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
    .id_ready(id_ready), .if_valid(if_valid2), .if_instr(if_instr2), .if_pc(if_pc2),
    .if_flush(if_flush2)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched2), .perf_flushes(perf_flushes2), .perf_stall(perf_stall2)
`endif
  );

  // Reference model: a queue of {pc, instr} plus one pending response.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  logic [31:0] m_resp_pc;
  bit          m_inflight;
  logic [31:0] m_fetched, m_flushes, m_stall;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sat(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 1;
  endfunction

  task automatic cycle(input logic rst, input logic rv, input logic [31:0] rpc, input logic rdy);
    bit   exp_valid;
    bit   exp_req;
    ent_t e;
    reset = rst; redirect_valid = rv; redirect_pc = rpc; id_ready = rdy;
    #1;
    exp_valid = (mq.size() != 0);
    exp_req   = !rst && !rv && ((mq.size() + (m_inflight ? 1 : 0)) < QD);
    check("if_valid", {31'd0, if_valid}, {31'd0, exp_valid});
    check("if_pc",    if_pc,    exp_valid ? mq[0].pc    : 32'd0);
    check("if_instr", if_instr, exp_valid ? mq[0].instr : 32'd0);
    check("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
    if (exp_req) check("imem_addr", {26'd0, imem_addr}, {26'd0, m_pc[7:2]});
    check("if_flush", {31'd0, if_flush}, {31'd0, rv});
`ifdef FETCH_PERF_EN
    check("perf_fetched", perf_fetched, m_fetched);
    check("perf_flushes", perf_flushes, m_flushes);
    check("perf_stall",   perf_stall,   m_stall);
`endif
    if (rst) begin
      mq.delete();
      m_inflight = 0;
      m_pc       = 32'h0;
      m_fetched  = 0; m_flushes = 0; m_stall = 0;
    end else begin
      if ((mq.size() == QD) && !rdy) m_stall = sat(m_stall);
      if (rv) begin
        mq.delete();
        m_inflight = 0;
        m_pc       = rpc & ~32'd3;
        m_flushes  = sat(m_flushes);
      end else begin
        if (exp_valid && rdy) void'(mq.pop_front());
        if (m_inflight) begin
          e.pc = m_resp_pc;
          e.instr = rom(m_resp_pc[7:2]);
          mq.push_back(e);
          m_fetched = sat(m_fetched);
        end
        m_inflight = exp_req;
        if (exp_req) begin
          m_resp_pc = m_pc;
          m_pc      = m_pc + 32'd4;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit found;
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b1;
    m_pc = 0; m_resp_pc = 0; m_inflight = 0; m_fetched = 0; m_flushes = 0; m_stall = 0;
    @(posedge clk); #1;

    // Reset state, with a redirect attempted during reset.
    cycle(1, 0, 32'h0, 1);
    cycle(1, 1, 32'h80, 1);
    cycle(1, 0, 32'h0, 1);

    // Reset release: first instruction two cycles later, then one per cycle.
    cycle(0, 0, 32'h0, 1);
    cycle(0, 0, 32'h0, 1);
    check("first_pc", if_pc, 32'h0);
    check("first_instr", if_instr, 32'h1000_0000);
    check("wrap_first_pc", if_pc2, 32'hFFFF_FFFC);
    check("wrap_first_instr", if_instr2, 32'h1000_003F);
    cycle(0, 0, 32'h0, 1);
    check("second_pc", if_pc, 32'h4);
    check("wrap_second_pc", if_pc2, 32'h0);
    check("wrap_second_instr", if_instr2, 32'h1000_0000);
    for (int i = 0; i < 5; i++) cycle(0, 0, 32'h0, 1);

    // Stall: queue fills and fetch stops, then drains in order.
    for (int i = 0; i < 10; i++) cycle(0, 0, 32'h0, 0);
    check("full_no_req", {31'd0, imem_req}, 32'd0);
    for (int i = 0; i < 8; i++) cycle(0, 0, 32'h0, 1);

    // Redirect while three entries are queued and one response is in flight.
    cycle(1, 0, 32'h0, 0);
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (mq.size() == 3 && m_inflight) found = 1;
      else cycle(0, 0, 32'h0, 0);
    end
    check("reach_q3_inflight", {31'd0, found}, 32'd1);
    cycle(0, 1, 32'h40, 1);
    check("flush_empty", {31'd0, if_valid}, 32'd0);
    cycle(0, 0, 32'h0, 1);
    cycle(0, 0, 32'h0, 1);
    check("redirect_target_pc", if_pc, 32'h40);
    cycle(0, 0, 32'h0, 1);

    // Unaligned target with a simultaneous pop.
    cycle(0, 1, 32'h43, 1);
    check("flush_pop_empty", {31'd0, if_valid}, 32'd0);
    cycle(0, 0, 32'h0, 1);
    cycle(0, 0, 32'h0, 1);
    check("aligned_target_pc", if_pc, 32'h40);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic r_rst, r_rv, r_rdy;
      logic [31:0] r_pc;
      r_rst = ($urandom_range(0, 99) == 0);
      r_rv  = ($urandom_range(0, 15) == 0);
      r_rdy = ($urandom_range(0, 3) != 0);
      r_pc  = $urandom;
      cycle(r_rst, r_rv, r_pc, r_rdy);
    end

    // Full queue then reset.
    for (int i = 0; i < 10; i++) cycle(0, 0, 32'h0, 0);
    check("full_before_reset", {31'd0, if_valid}, 32'd1);
    cycle(1, 0, 32'h0, 0);
    check("reset_clears_valid", {31'd0, if_valid}, 32'd0);
`ifdef FETCH_PERF_EN
    check("reset_perf_fetched", perf_fetched, 32'd0);
    check("reset_perf_stall", perf_stall, 32'd0);
`endif
    cycle(1, 0, 32'h0, 0);
    cycle(0, 0, 32'h0, 1);
    cycle(0, 0, 32'h0, 1);
    check("restart_pc", if_pc, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
